// File: rtl/load_pkg.sv
// Shared types for the load/writeback unit: RV32I load funct3 codes, fault causes,
// FSM states, and the request decode that classifies a load before it reaches memory.
package load_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_ILLEGAL  = 2'b10,
    CAUSE_BUS      = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_WB   = 2'b10
  } state_e;

  // Illegal funct3 takes priority over misalignment.
  function automatic cause_e decode_fault(input logic [2:0] f3, input logic [1:0] off);
    cause_e c;
    c = CAUSE_NONE;
    unique case (f3)
      3'b011, 3'b110, 3'b111: c = CAUSE_ILLEGAL;
      3'b001, 3'b101:         if (off[0])      c = CAUSE_MISALIGN;
      3'b010:                 if (off != 2'b00) c = CAUSE_MISALIGN;
      default:                c = CAUSE_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment: selects the addressed byte/half of the returned
// word and sign- or zero-extends it according to funct3.
module load_align
  import load_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  funct3_e          funct3,
  input  logic [1:0]       offset,
  input  logic [XLEN-1:0]  word,
  output logic [XLEN-1:0]  data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[8*offset +: 8];
    half_v = word[16*offset[1] +: 16];
  end

  always_comb begin
    data = word;
    unique case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   data = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_v};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_writeback_unit.sv
// RV32I load unit: accepts one load, performs a req/ack memory read with timeout,
// aligns/extends the result and drives a one-cycle register file write or a fault pulse.
module load_writeback_unit
  import load_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [2:0]      ld_funct3,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [4:0]      ld_rd,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_err,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            fault,
  output logic [1:0]      fault_cause
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  funct3_e         f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [4:0]      rd_q, rd_d;

  logic            ld_ready_q, ld_ready_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            fault_q, fault_d;
  cause_e          cause_q, cause_d;

  logic            accept;
  cause_e          req_fault;
  logic [XLEN-1:0] aligned;

  assign accept    = ld_valid && ld_ready_q;
  assign req_fault = decode_fault(ld_funct3, ld_addr[1:0]);

  load_align #(.XLEN(XLEN)) u_align (
    .funct3 (f3_q),
    .offset (off_q),
    .word   (mem_rdata),
    .data   (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept && req_fault == CAUSE_NONE) state_d = S_WAIT;
      S_WAIT: begin
        if (mem_ack)                   state_d = mem_err ? S_IDLE : S_WB;
        else if (cnt_q == TIMEOUT_VAL) state_d = S_IDLE;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered: each _d is the value the port shows in the next cycle,
  // so wb_en is raised on the ack edge and is high while the FSM sits in WB.
  always_comb begin
    ld_ready_d = (state_d == S_IDLE);
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    wb_en_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    fault_d    = 1'b0;
    cause_d    = CAUSE_NONE;
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    off_d      = off_q;
    rd_d       = rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_fault != CAUSE_NONE) begin
            fault_d = 1'b1;
            cause_d = req_fault;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = {ld_addr[XLEN-1:2], 2'b00};
            f3_d       = funct3_e'(ld_funct3);
            off_d      = ld_addr[1:0];
            rd_d       = ld_rd;
          end
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          if (mem_err) begin
            fault_d = 1'b1;
            cause_d = CAUSE_BUS;
          end else if (rd_q != 5'd0) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = rd_q;
            wb_data_d = aligned;
          end
        end else if (cnt_q == TIMEOUT_VAL) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          fault_d   = 1'b1;
          cause_d   = CAUSE_BUS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ready_q <= 1'b1;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      fault_q    <= 1'b0;
      cause_q    <= CAUSE_NONE;
      cnt_q      <= '0;
      f3_q       <= F3_LB;
      off_q      <= '0;
      rd_q       <= '0;
    end else begin
      ld_ready_q <= ld_ready_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wb_en_q    <= wb_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
    end
  end

  assign ld_ready    = ld_ready_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign wb_en       = wb_en_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Scoreboard bench for load_writeback_unit: stimulus pushes expected writebacks/faults,
// a negedge monitor pops and compares whenever wb_en or fault is presented.
module tb_load_writeback_unit;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_funct3;
  logic [31:0] ld_addr;
  logic [4:0]  ld_rd;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;
  logic [1:0]  fault_cause;

  load_writeback_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_funct3   (ld_funct3),
    .ld_addr     (ld_addr),
    .ld_rd       (ld_rd),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .mem_err     (mem_err),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_fault;
    logic [1:0]  cause;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.is_fault = 1'b0; e.cause = 2'b00; e.rd = rd; e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_fault(input logic [1:0] c);
    exp_t e;
    e.is_fault = 1'b1; e.cause = c; e.rd = '0; e.data = '0;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && (wb_en === 1'b1 || fault === 1'b1)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: wb_en=%b wb_rd=%0d wb_data=%h fault=%b cause=%b",
                 wb_en, wb_rd, wb_data, fault, fault_cause);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_fault) begin
          check("fault_flag", 32'(fault), 32'd1);
          check("fault_cause", 32'(fault_cause), 32'(mon_e.cause));
          check("no_wb_on_fault", 32'(wb_en), 32'd0);
        end else begin
          check("wb_en", 32'(wb_en), 32'd1);
          check("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
          check("wb_data", wb_data, mon_e.data);
        end
      end
    end
  end

  // All tasks start and end 1ns after a rising edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
    int n;
    n = 0;
    while (ld_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL ld_ready_wait: got %b want 1", ld_ready);
    end
    ld_valid  = 1'b1;
    ld_funct3 = f3;
    ld_addr   = a;
    ld_rd     = rd;
    @(posedge clk); #1;
    ld_valid  = 1'b0;
  endtask

  task automatic serve(input int dly, input logic [31:0] d, input logic err,
                       input logic [31:0] exp_addr);
    check("mem_req_up", 32'(mem_req), 32'd1);
    check("mem_addr", mem_addr, exp_addr);
    repeat (dly) begin
      @(posedge clk); #1;
    end
    mem_ack   = 1'b1;
    mem_rdata = d;
    mem_err   = err;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_err   = 1'b0;
    check("mem_req_drop", 32'(mem_req), 32'd0);
  endtask

  localparam logic [31:0] RD_WORD = 32'h80FF7F01;

  logic [2:0]  a_f3  [9] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
  logic [31:0] a_adr [9] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h102, 32'h100, 32'h100, 32'h100};
  logic [31:0] a_exp [9] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                             32'h0000007F, 32'hFFFFFFFF, 32'h00000001, 32'h00007F01, 32'h00007F01};

  logic [2:0]  f_f3  [7] = '{3'b010, 3'b001, 3'b101, 3'b011, 3'b110, 3'b111, 3'b111};
  logic [31:0] f_adr [7] = '{32'h102, 32'h101, 32'h103, 32'h100, 32'h100, 32'h100, 32'h101};
  logic [1:0]  f_exp [7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};

  initial begin
    int n;
    rst_n = 1'b0; ld_valid = 1'b0; ld_funct3 = '0; ld_addr = '0; ld_rd = '0;
    mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_cause", 32'(fault_cause), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LW with ack two cycles after req, and latency of wb_en / ld_ready
    push_wb(5'd5, 32'hDEADBEEF);
    issue(3'b010, 32'h100, 5'd5);
    check("ld_ready_busy", 32'(ld_ready), 32'd0);
    serve(2, 32'hDEADBEEF, 1'b0, 32'h100);
    check("wb_en_m1", 32'(wb_en), 32'd1);
    check("ld_ready_m1", 32'(ld_ready), 32'd0);
    @(posedge clk); #1;
    check("wb_en_m2", 32'(wb_en), 32'd0);
    check("ld_ready_m2", 32'(ld_ready), 32'd1);
    check("wb_data_hold", wb_data, 32'hDEADBEEF);

    // alignment and extension
    for (int i = 0; i < 9; i++) begin
      push_wb(5'(i + 1), a_exp[i]);
      issue(a_f3[i], a_adr[i], 5'(i + 1));
      serve(1, RD_WORD, 1'b0, {a_adr[i][31:2], 2'b00});
    end

    // decode faults: no memory request, stay ready
    for (int i = 0; i < 7; i++) begin
      push_fault(f_exp[i]);
      issue(f_f3[i], f_adr[i], 5'd7);
      for (int k = 0; k < 3; k++) begin
        check("fault_no_req", 32'(mem_req), 32'd0);
        check("fault_ready", 32'(ld_ready), 32'd1);
        @(posedge clk); #1;
      end
    end

    // rd=0: access performed, no write
    issue(3'b010, 32'h200, 5'd0);
    serve(1, 32'h12345678, 1'b0, 32'h200);
    repeat (2) @(posedge clk);
    #1;

    // bus error
    push_fault(2'b11);
    issue(3'b010, 32'h204, 5'd9);
    serve(1, 32'h0, 1'b1, 32'h204);
    @(posedge clk); #1;

    // timeout, then a late ack that must be ignored
    push_fault(2'b11);
    issue(3'b010, 32'h300, 5'd4);
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n < TO || n > TO + 1) begin
      bad++;
      $display("FAIL timeout_req_cycles: got %0d want %0d..%0d", n, TO, TO + 1);
    end
    mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_ready", 32'(ld_ready), 32'd1);

    // reset while waiting, then a normal load
    issue(3'b010, 32'h400, 5'd3);
    #3 rst_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    check("arst_ld_ready", 32'(ld_ready), 32'd1);
    check("arst_wb_en", 32'(wb_en), 32'd0);
    check("arst_wb_data", wb_data, 32'd0);
    check("arst_fault", 32'(fault), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_wb(5'd6, 32'hCAFEF00D);
    issue(3'b010, 32'h404, 5'd6);
    serve(2, 32'hCAFEF00D, 1'b0, 32'h404);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
